ctrl_sequencer: RTL and testbench

- Control-step sequencer feeding the Datapath directly; generates, clock by clock, the strobes that the datapath bench currently drives by hand for T0..T6.
- Fetches an instruction, decodes IR[31:27], and runs register-register ALU, MUL/DIV (HI/LO) or NOP/HALT sequences.
- Register-file access uses Gra/Grb/Grc field selects plus shared Rin/Rout. The datapath's select-and-encode logic maps these to R0..R15.

---
 rtl/ctrl_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// Control-step sequencer: IDLE, T0..T6, HALT strobe generator for the datapath.
// Optional SEQ_ILLEGAL_TRAP_EN: illegal opcodes halt and set sticky IllegalOp.
module ctrl_sequencer (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        Run,
  input  logic        MemReady,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic [4:0]  ctl,
  output logic        InstrDone,
`ifdef SEQ_ILLEGAL_TRAP_EN
  output logic        IllegalOp,
`endif
  output logic        Halted
);

  localparam logic [4:0] MUL_OP  = 5'b01001;
  localparam logic [4:0] DIV_OP  = 5'b01010;
  localparam logic [4:0] NOP_OP  = 5'b11110;
  localparam logic [4:0] HALT_OP = 5'b11111;
  localparam logic [4:0] ALU_MAX = 5'b01000;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic       t1_first;
  logic [4:0] op;
  logic       op_alu;
  logic       op_md;
  logic       op_nop;
  logic       op_halt;
  logic       op_bad;
  logic       op_trap;
  logic       op_skip;
  logic [3:0] eoi_state;
  logic       unused_ir;

  assign op        = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign op_alu    = (op <= ALU_MAX);
  assign op_md     = (op == MUL_OP) || (op == DIV_OP);
  assign op_nop    = (op == NOP_OP);
  assign op_halt   = (op == HALT_OP);
  assign op_bad    = !(op_alu || op_md || op_nop || op_halt);

`ifdef SEQ_ILLEGAL_TRAP_EN
  assign op_trap = op_bad;
  assign op_skip = op_nop;
`else
  assign op_trap = 1'b0;
  assign op_skip = op_nop || op_bad;
`endif

  assign eoi_state = Run ? S_T0 : S_IDLE;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: state_nxt = Run ? S_T0 : S_IDLE;
      S_T0:   state_nxt = S_T1;
      S_T1:   state_nxt = MemReady ? S_T2 : S_T1;
      S_T2:   state_nxt = S_T3;
      S_T3: begin
        unique case (1'b1)
          op_halt: state_nxt = S_HALT;
          op_trap: state_nxt = S_HALT;
          op_skip: state_nxt = eoi_state;
          default: state_nxt = S_T4;
        endcase
      end
      S_T4:   state_nxt = S_T5;
      S_T5:   state_nxt = op_md ? S_T6 : eoi_state;
      S_T6:   state_nxt = eoi_state;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // t1_first marks the first T1 cycle so the PC is loaded once per fetch
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state    <= S_IDLE;
      t1_first <= 1'b0;
    end else begin
      state    <= state_nxt;
      t1_first <= (state == S_T0);
    end
  end

`ifdef SEQ_ILLEGAL_TRAP_EN
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      IllegalOp <= 1'b0;
    end else if (state == S_T3 && op_bad) begin
      IllegalOp <= 1'b1;
    end
  end
`endif

  always_comb begin
    PCout     = 1'b0;
    PCin      = 1'b0;
    IncPC     = 1'b0;
    MARin     = 1'b0;
    Read      = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    Zlowout   = 1'b0;
    Zhighout  = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    Rin       = 1'b0;
    Rout      = 1'b0;
    ctl       = 5'd0;
    InstrDone = 1'b0;
    Halted    = 1'b0;
    unique case (state)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Read    = 1'b1;
        MDRin   = 1'b1;
        Zlowout = t1_first;
        PCin    = t1_first;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (op_halt || op_skip) begin
          InstrDone = 1'b1;
        end else if (!op_trap) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end
      end
      S_T4: begin
        Grc  = 1'b1;
        Rout = 1'b1;
        Zin  = 1'b1;
        ctl  = op;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (op_md) begin
          LOin = 1'b1;
        end else begin
          Gra       = 1'b1;
          Rin       = 1'b1;
          InstrDone = 1'b1;
        end
      end
      S_T6: begin
        Zhighout  = 1'b1;
        HIin      = 1'b1;
        InstrDone = 1'b1;
      end
      S_HALT: Halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed, table-driven bench for ctrl_sequencer (default build).
// Each vector: inputs before an edge, expected outputs after it.
module tb_ctrl_sequencer;

  logic        Clock = 1'b0;
  logic        Clear = 1'b0;
  logic        Run = 1'b0;
  logic        MemReady = 1'b0;
  logic [31:0] IR = 32'd0;
  logic PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
  logic Yin, Zin, Zlowout, Zhighout, HIin, LOin;
  logic Gra, Grb, Grc, Rin, Rout, InstrDone, Halted;
  logic [4:0] ctl;

  int checks = 0;
  int errors = 0;

  ctrl_sequencer dut (
    .Clock(Clock), .Clear(Clear), .Run(Run), .MemReady(MemReady),
    .IR(IR), .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
    .MARin(MARin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .Gra(Gra),
    .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .ctl(ctl),
    .InstrDone(InstrDone), .Halted(Halted)
  );

  always #5 Clock = ~Clock;

  localparam logic [18:0] PCOUT  = 19'h40000;
  localparam logic [18:0] PCIN   = 19'h20000;
  localparam logic [18:0] INCPC  = 19'h10000;
  localparam logic [18:0] MARIN  = 19'h08000;
  localparam logic [18:0] READ   = 19'h04000;
  localparam logic [18:0] MDRIN  = 19'h02000;
  localparam logic [18:0] MDROUT = 19'h01000;
  localparam logic [18:0] IRIN   = 19'h00800;
  localparam logic [18:0] YIN    = 19'h00400;
  localparam logic [18:0] ZIN    = 19'h00200;
  localparam logic [18:0] ZLO    = 19'h00100;
  localparam logic [18:0] ZHI    = 19'h00080;
  localparam logic [18:0] HIIN   = 19'h00040;
  localparam logic [18:0] LOIN   = 19'h00020;
  localparam logic [18:0] GRA    = 19'h00010;
  localparam logic [18:0] GRB    = 19'h00008;
  localparam logic [18:0] GRC    = 19'h00004;
  localparam logic [18:0] RIN    = 19'h00002;
  localparam logic [18:0] ROUT   = 19'h00001;

  localparam logic [18:0] E_T0  = PCOUT | MARIN | INCPC | ZIN;
  localparam logic [18:0] E_T1F = READ | MDRIN | ZLO | PCIN;
  localparam logic [18:0] E_T1  = READ | MDRIN;
  localparam logic [18:0] E_T2  = MDROUT | IRIN;
  localparam logic [18:0] E_T3  = GRB | ROUT | YIN;
  localparam logic [18:0] E_T4  = GRC | ROUT | ZIN;
  localparam logic [18:0] E_T5A = ZLO | GRA | RIN;
  localparam logic [18:0] E_T5M = ZLO | LOIN;
  localparam logic [18:0] E_T6  = ZHI | HIIN;

  localparam logic [31:0] IR_MUL  = 32'h4A920000;
  localparam logic [31:0] IR_ALU  = 32'h1A920000;
  localparam logic [31:0] IR_NOP  = 32'hF0000000;
  localparam logic [31:0] IR_BAD  = 32'h58000000;
  localparam logic [31:0] IR_HALT = 32'hF8000000;

  typedef struct {
    logic        run;
    logic        mr;
    logic [31:0] ir;
    logic [18:0] strb;
    logic [4:0]  ctl;
    logic        done;
    logic        halt;
  } vec_t;

  vec_t vq[$];

  wire [18:0] strb = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout,
                      IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin,
                      Gra, Grb, Grc, Rin, Rout};

  task automatic check(input string nm, input logic [18:0] es,
                       input logic [4:0] ec, input logic ed,
                       input logic eh);
    checks++;
    if ({strb, ctl, InstrDone, Halted} !== {es, ec, ed, eh}) begin
      errors++;
      $display("FAIL %s: got strb=%h ctl=%h done=%b halt=%b want strb=%h ctl=%h done=%b halt=%b",
               nm, strb, ctl, InstrDone, Halted, es, ec, ed, eh);
    end
  endtask

  task automatic add(input logic r, input logic m, input logic [31:0] i,
                     input logic [18:0] s, input logic [4:0] c,
                     input logic d, input logic h);
    vec_t v;
    v.run = r; v.mr = m; v.ir = i;
    v.strb = s; v.ctl = c; v.done = d; v.halt = h;
    vq.push_back(v);
  endtask

  task automatic step(input logic r, input logic m, input logic [31:0] i);
    Run = r;
    MemReady = m;
    IR = i;
    @(posedge Clock);
    @(negedge Clock);
  endtask

  initial begin
    // MUL: T0..T6
    add(1, 1, IR_MUL, E_T0,  5'd0, 0, 0);
    add(1, 1, IR_MUL, E_T1F, 5'd0, 0, 0);
    add(1, 1, IR_MUL, E_T2,  5'd0, 0, 0);
    add(1, 1, IR_MUL, E_T3,  5'd0, 0, 0);
    add(1, 1, IR_MUL, E_T4,  5'b01001, 0, 0);
    add(1, 1, IR_MUL, E_T5M, 5'd0, 0, 0);
    add(1, 1, IR_MUL, E_T6,  5'd0, 1, 0);
    // ALU op 3, back to back
    add(1, 1, IR_ALU, E_T0,  5'd0, 0, 0);
    add(1, 1, IR_ALU, E_T1F, 5'd0, 0, 0);
    add(1, 1, IR_ALU, E_T2,  5'd0, 0, 0);
    add(1, 1, IR_ALU, E_T3,  5'd0, 0, 0);
    add(1, 1, IR_ALU, E_T4,  5'b00011, 0, 0);
    add(1, 1, IR_ALU, E_T5A, 5'd0, 1, 0);
    add(0, 1, IR_ALU, 19'd0, 5'd0, 0, 0);
    add(0, 1, IR_ALU, 19'd0, 5'd0, 0, 0);
    // T1 stall of 3 cycles, then NOP
    add(1, 1, IR_NOP, E_T0,  5'd0, 0, 0);
    add(1, 0, IR_NOP, E_T1F, 5'd0, 0, 0);
    add(0, 0, IR_NOP, E_T1,  5'd0, 0, 0);
    add(0, 0, IR_NOP, E_T1,  5'd0, 0, 0);
    add(0, 0, IR_NOP, E_T1,  5'd0, 0, 0);
    add(0, 1, IR_NOP, E_T2,  5'd0, 0, 0);
    add(0, 1, IR_NOP, 19'd0, 5'd0, 1, 0);
    add(0, 1, IR_NOP, 19'd0, 5'd0, 0, 0);
    // illegal opcode behaves as NOP
    add(1, 1, IR_BAD, E_T0,  5'd0, 0, 0);
    add(1, 1, IR_BAD, E_T1F, 5'd0, 0, 0);
    add(1, 1, IR_BAD, E_T2,  5'd0, 0, 0);
    add(0, 1, IR_BAD, 19'd0, 5'd0, 1, 0);
    add(0, 1, IR_BAD, 19'd0, 5'd0, 0, 0);
    // HALT
    add(1, 1, IR_HALT, E_T0,  5'd0, 0, 0);
    add(1, 1, IR_HALT, E_T1F, 5'd0, 0, 0);
    add(1, 1, IR_HALT, E_T2,  5'd0, 0, 0);
    add(1, 1, IR_HALT, 19'd0, 5'd0, 1, 0);
    add(1, 1, IR_HALT, 19'd0, 5'd0, 0, 1);

    Clear = 1'b0;
    repeat (2) begin
      @(negedge Clock);
      check("reset_low", 19'd0, 5'd0, 0, 0);
    end
    Clear = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(0, 0, IR_MUL);
      check($sformatf("idle%0d", k), 19'd0, 5'd0, 0, 0);
    end

    for (int k = 0; k < vq.size(); k++) begin
      step(vq[k].run, vq[k].mr, vq[k].ir);
      check($sformatf("vec%0d", k), vq[k].strb, vq[k].ctl,
            vq[k].done, vq[k].halt);
    end

    for (int k = 0; k < 10; k++) begin
      step(1, 1, IR_ALU);
      check($sformatf("halt_hold%0d", k), 19'd0, 5'd0, 0, 1);
    end
    Clear = 1'b0;
    #1;
    check("halt_clear", 19'd0, 5'd0, 0, 0);
    @(negedge Clock);
    Clear = 1'b1;
    step(0, 1, IR_ALU);
    check("halt_idle", 19'd0, 5'd0, 0, 0);

    // asynchronous clear during T4
    for (int k = 0; k < 5; k++) step(1, 1, IR_ALU);
    check("mid_t4", E_T4, 5'b00011, 0, 0);
    #2;
    Clear = 1'b0;
    #1;
    check("mid_clear", 19'd0, 5'd0, 0, 0);
    @(negedge Clock);
    Clear = 1'b1;
    step(1, 1, IR_ALU);
    check("restart_t0", E_T0, 5'd0, 0, 0);
    step(1, 1, IR_ALU);
    check("restart_t1", E_T1F, 5'd0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
